imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64 only.
REQ-002 SHALL have parameter DEPTH, default 2, number of buffer entries; legal values 2 to 8.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream presents an instruction.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port in_instr  input  32  raw instruction word.
REQ-008 SHALL have port in_imm_src  input  3  immediate format select.
REQ-009 SHALL have port out_valid  output  1  head entry holds a valid immediate.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the head entry.
REQ-011 SHALL have port out_imm  output  XLEN  decoded immediate of the head entry.
REQ-012 SHALL have port out_illegal  output  1  head entry had an unsupported format select.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-014 Push SHALL occur on a rising clk edge when in_valid and in_ready are both 1. Pop SHALL occur on a rising clk edge when out_valid and out_ready are both 1.
REQ-015 Decode SHALL be computed combinationally from in_instr and in_imm_src at push time. Only the decoded immediate and illegal flag SHALL be stored.
REQ-016 Format 000 (I) SHALL produce sext(instr[31:20]).
REQ-017 Format 001 (S) SHALL produce sext({instr[31:25], instr[11:7]}).
REQ-018 Format 010 (B) SHALL produce sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); the sign bit is instr[31].
REQ-019 Format 011 (U) SHALL produce sext({instr[31:12], 12'b0}).
REQ-020 Format 100 (J) SHALL produce sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-021 Format 101 (Z, CSR immediate) SHALL produce zext(instr[19:15]).
REQ-022 Format 110 (SHAMT) SHALL produce zext(instr[25:20]) when XLEN=64 and zext(instr[24:20]) when XLEN=32.
REQ-023 Format 111 SHALL store immediate 0 with out_illegal=1. All other formats SHALL store out_illegal=0.
REQ-024 Sign extension SHALL replicate instr[31] up to bit XLEN-1.
REQ-025 Latency SHALL be 1 cycle: an entry pushed at edge N SHALL be visible on out_* after edge N when the buffer was empty before that edge.
REQ-026 The buffer SHALL be FIFO ordered, using read and write pointers that wrap modulo DEPTH.
REQ-027 in_ready SHALL equal (count < DEPTH). It SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-028 out_valid SHALL equal (count != 0). out_imm and out_illegal SHALL show the head entry.
REQ-029 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-030 When full, in_valid SHALL be ignored until a pop has registered (one-cycle bubble).
REQ-031 When empty, out_ready SHALL be ignored and count SHALL NOT underflow.
REQ-032 While out_valid=1 and out_ready=0, out_imm and out_illegal SHALL remain stable.

Reset
REQ-033 rst_n low SHALL immediately force count=0, both pointers=0, out_valid=0, and in_ready=1.
REQ-034 While rst_n is low, out_imm and out_illegal SHALL read 0.
REQ-035 Entries in flight at reset SHALL be discarded.
REQ-036 The first push SHALL be accepted on the first rising edge after rst_n is deasserted.

Verification
REQ-037 I-type: in_instr=0xFFF00093, src=000, out_ready=1, XLEN=32 -> next cycle out_imm=0xFFFFFFFF, out_illegal=0; with XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
REQ-038 B and U formats:
- 0xFE000EE3 with src=010 -> 0xFFFFFFFC.
- 0x123450B7 with src=011 -> 0x12345000.
- Sent back-to-back, the outputs SHALL appear on consecutive cycles in that order.
REQ-039 Backpressure, DEPTH=2, out_ready=0:
- Present three instructions -> first two accepted, count=2, in_ready=0, third held.
- Then out_ready=1 -> outputs appear in order.
- The third instruction is accepted one cycle after the first pop.
REQ-040 Illegal and Z formats:
- src=111 with any instr -> out_imm=0, out_illegal=1.
- src=101 with instr[19:15]=5'h1F -> out_imm=0x0000001F.
REQ-041 Reset mid-operation: count=2, drive rst_n low between edges -> out_valid=0, count=0, in_ready=1 without waiting for a clock edge. After release, a new push emerges alone.
REQ-042 Simultaneous push and pop at count=1 for 10 cycles -> count stays 1 and the outputs match the inputs delayed by one.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Immediate decoder feeding a small valid/ready FIFO. Only the decoded
// immediate and its illegal flag are stored; out_* always present the head entry.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [2:0]                   in_imm_src,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_imm,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [DEPTH-1:0] ill_mem_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;
  logic             push, pop;

  // Every format is first built as a 32-bit value that is already correctly
  // extended to 32 bits; widening to XLEN is then a plain sign extension.
  always_comb begin
    imm32   = '0;
    dec_ill = 1'b0;
    case (in_imm_src)
      3'b000: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
      3'b011: imm32 = {in_instr[31:12], 12'b0};
      3'b100: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
      3'b101: imm32 = {27'b0, in_instr[19:15]};
      3'b110: imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                   : {27'b0, in_instr[24:20]};
      default: begin
        imm32   = '0;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign dec_imm = XLEN'($signed(imm32));

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: its contents are only observable while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem_q[wr_ptr_q] <= dec_imm;
      ill_mem_q[wr_ptr_q] <= dec_ill;
    end
  end

  assign out_imm     = out_valid ? imm_mem_q[rd_ptr_q] : '0;
  assign out_illegal = out_valid ? ill_mem_q[rd_ptr_q] : 1'b0;
  assign count       = count_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// checked against a queue model with an arithmetic immediate decoder.
module tb_imm_gen_pipe;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [1:0]  count32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [1:0]  count64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] i64;
    logic [31:0] i32;
    logic        ill;
  } entry_t;
  entry_t q[$];

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_illegal(out_illegal32),
    .count(count32));

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_illegal(out_illegal64),
    .count(count64));

  always #5 clk = ~clk;

  function automatic longint sx(input longint v, input int n);
    longint half;
    half = longint'(1) << (n - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] x, input logic [2:0] s, input int xl);
    longint v;
    case (s)
      3'd0: v = sx(longint'(x[31:20]), 12);
      3'd1: v = sx(longint'(x[31:25]) * 32 + longint'(x[11:7]), 12);
      3'd2: v = sx(longint'(x[31]) * 4096 + longint'(x[7]) * 2048 +
                   longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2, 13);
      3'd3: v = sx(longint'(x[31:12]) * 4096, 32);
      3'd4: v = sx(longint'(x[31]) * 1048576 + longint'(x[19:12]) * 4096 +
                   longint'(x[20]) * 2048 + longint'(x[30:21]) * 2, 21);
      3'd5: v = longint'(x[19:15]);
      3'd6: v = (xl == 64) ? longint'(x[25:20]) : longint'(x[24:20]);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count32",     64'(count32),     64'(n));
    chk("count64",     64'(count64),     64'(n));
    chk("in_ready32",  64'(in_ready32),  64'(n < DEPTH));
    chk("in_ready64",  64'(in_ready64),  64'(n < DEPTH));
    chk("out_valid32", 64'(out_valid32), 64'(n != 0));
    chk("out_valid64", 64'(out_valid64), 64'(n != 0));
    chk("out_imm32",   64'(out_imm32),   (n != 0) ? 64'(q[0].i32) : 64'd0);
    chk("out_imm64",   out_imm64,        (n != 0) ? q[0].i64 : 64'd0);
    chk("out_ill32",   64'(out_illegal32), (n != 0) ? 64'(q[0].ill) : 64'd0);
    chk("out_ill64",   64'(out_illegal64), (n != 0) ? 64'(q[0].ill) : 64'd0);
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic ordy);
    bit do_push, do_pop;
    entry_t e;
    in_valid   = v;
    in_instr   = ins;
    in_imm_src = src;
    out_ready  = ordy;
    @(posedge clk);
    do_push = v && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    e.i64 = ref_imm(ins, src, 64);
    e.i32 = ref_imm(ins, src, 32) & 64'hFFFF_FFFF;
    e.ill = (src == 3'd7);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(e);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_imm_src = '0; out_ready = 1'b0;
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // I-type on the first edge after reset release
    step(1'b1, 32'hFFF00093, 3'd0, 1'b1);
    chk("i_type32", 64'(out_imm32), 64'hFFFF_FFFF);
    chk("i_type64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("i_ill", 64'(out_illegal32), 64'd0);

    // B then U back-to-back
    step(1'b1, 32'hFE000EE3, 3'd2, 1'b1);
    chk("b_type32", 64'(out_imm32), 64'hFFFF_FFFC);
    chk("b_type64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 32'h123450B7, 3'd3, 1'b1);
    chk("u_type32", 64'(out_imm32), 64'h1234_5000);
    chk("u_type64", out_imm64, 64'h1234_5000);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    chk("drain", 64'(count32), 64'd0);

    // Backpressure: third instruction held until one cycle after the first pop
    step(1'b1, 32'hFFF00093, 3'd0, 1'b0);
    step(1'b1, 32'h000F8000, 3'd5, 1'b0);
    step(1'b1, 32'hDEADBEEF, 3'd7, 1'b0);
    chk("bp_full_count", 64'(count32), 64'd2);
    chk("bp_full_ready", 64'(in_ready32), 64'd0);
    step(1'b1, 32'hDEADBEEF, 3'd7, 1'b1);
    chk("bp_pop1_count", 64'(count32), 64'd1);
    chk("z_type", 64'(out_imm32), 64'h1F);
    step(1'b1, 32'hDEADBEEF, 3'd7, 1'b1);
    chk("illegal_imm", 64'(out_imm32), 64'd0);
    chk("illegal_flag", 64'(out_illegal32), 64'd1);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    chk("bp_empty", 64'(out_valid32), 64'd0);
    step(1'b0, 32'h0, 3'd0, 1'b1);   // pop on empty must not underflow

    // Asynchronous reset with two entries in flight
    step(1'b1, 32'h00500093, 3'd0, 1'b0);
    step(1'b1, 32'h80000037, 3'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("rst_count", 64'(count32), 64'd0);
    chk("rst_valid", 64'(out_valid32), 64'd0);
    chk("rst_ready", 64'(in_ready32), 64'd1);
    chk("rst_imm64", out_imm64, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 32'h02A00513, 3'd0, 1'b0);
    chk("post_rst_alone", 64'(count32), 64'd1);
    chk("post_rst_imm", 64'(out_imm32), 64'd42);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    chk("post_rst_empty", 64'(count32), 64'd0);

    // Simultaneous push/pop at count=1 for 10 cycles
    step(1'b1, $urandom, 3'($urandom_range(0, 7)), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 3'($urandom_range(0, 7)), 1'b1);
      chk("pp_count", 64'(count32), 64'd1);
    end
    step(1'b0, 32'h0, 3'd0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
